// File: rtl/scene_fade_ctrl.sv
// Scene sequencer (INTRO->PLAY->OVER) with per-frame-group fade to black on every scene change.
// Colour path: 1-cycle latency; no backpressure, events arriving mid-fade or out of scene are dropped.
module scene_fade_ctrl #(
    parameter int FADE_FRAMES = 4,
    parameter int LVL_MAX     = 16
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       start_key,
    input  logic       game_over,
    input  logic       blank,
    input  logic [3:0] red_in,
    input  logic [3:0] green_in,
    input  logic [3:0] blue_in,
    output logic [1:0] scene,
    output logic       fade_busy,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    typedef enum logic [2:0] {
        INTRO_SHOW,
        PLAY_SHOW,
        OVER_SHOW,
        FADE_OUT,
        FADE_IN
    } state_t;

    localparam int              CW       = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(FADE_FRAMES - 1);
    localparam logic [4:0]      LVL_FULL = 5'(LVL_MAX);
    localparam logic [1:0]      SC_INTRO = 2'd0;
    localparam logic [1:0]      SC_PLAY  = 2'd1;
    localparam logic [1:0]      SC_OVER  = 2'd2;

    state_t        state, state_n;
    logic [1:0]    target, target_n, scene_n;
    logic [4:0]    level, level_n;
    logic [CW-1:0] frame_cnt, frame_cnt_n;
    logic          key_q;
    logic          key_rise;

    assign key_rise = start_key & ~key_q;

    function automatic logic [3:0] fade(input logic [3:0] c, input logic [4:0] l);
        return 4'(({5'd0, c} * {4'd0, l}) >> 4);
    endfunction

    always_comb begin
        state_n     = state;
        target_n    = target;
        scene_n     = scene;
        level_n     = level;
        frame_cnt_n = frame_cnt;
        fade_busy   = 1'b0;
        case (state)
            INTRO_SHOW: if (key_rise) begin
                state_n     = FADE_OUT;
                target_n    = SC_PLAY;
                frame_cnt_n = '0;
            end
            // game_over takes priority; key presses mean nothing during play
            PLAY_SHOW: if (game_over) begin
                state_n     = FADE_OUT;
                target_n    = SC_OVER;
                frame_cnt_n = '0;
            end
            OVER_SHOW: if (key_rise) begin
                state_n     = FADE_OUT;
                target_n    = SC_INTRO;
                frame_cnt_n = '0;
            end
            FADE_OUT: begin
                fade_busy = 1'b1;
                if (level == 5'd0) begin
                    // screen is black: safe to switch the mapper
                    state_n     = FADE_IN;
                    scene_n     = target;
                    frame_cnt_n = '0;
                end else if (frame_start) begin
                    if (frame_cnt == CNT_LAST) begin
                        frame_cnt_n = '0;
                        level_n     = level - 1'b1;
                    end else begin
                        frame_cnt_n = frame_cnt + 1'b1;
                    end
                end
            end
            FADE_IN: begin
                fade_busy = 1'b1;
                if (level == LVL_FULL) begin
                    case (target)
                        SC_PLAY: state_n = PLAY_SHOW;
                        SC_OVER: state_n = OVER_SHOW;
                        default: state_n = INTRO_SHOW;
                    endcase
                end else if (frame_start) begin
                    if (frame_cnt == CNT_LAST) begin
                        frame_cnt_n = '0;
                        level_n     = level + 1'b1;
                    end else begin
                        frame_cnt_n = frame_cnt + 1'b1;
                    end
                end
            end
            default: state_n = INTRO_SHOW;
        endcase
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            state     <= INTRO_SHOW;
            target    <= SC_INTRO;
            scene     <= SC_INTRO;
            level     <= LVL_FULL;
            frame_cnt <= '0;
            key_q     <= 1'b0;
        end else begin
            state     <= state_n;
            target    <= target_n;
            scene     <= scene_n;
            level     <= level_n;
            frame_cnt <= frame_cnt_n;
            key_q     <= start_key;
        end
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
        end else if (!blank) begin
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
        end else begin
            red   <= fade(red_in, level);
            green <= fade(green_in, level);
            blue  <= fade(blue_in, level);
        end
    end

endmodule

// File: tb/tb_scene_fade_ctrl.sv
// Scoreboard bench for scene_fade_ctrl: scripted scene/fade walk with queued RGB expectations.
module tb_scene_fade_ctrl;

    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       start_key = 1'b0;
    logic       game_over = 1'b0;
    logic       blank = 1'b1;
    logic [3:0] red_in = 4'hF;
    logic [3:0] green_in = 4'h8;
    logic [3:0] blue_in = 4'h1;
    logic [1:0] scene;
    logic       fade_busy;
    logic [3:0] red, green, blue;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string      tag;
        logic [11:0] rgb;
    } exp_t;
    exp_t exp_q[$];

    always #5 vga_clk = ~vga_clk;

    scene_fade_ctrl #(.FADE_FRAMES(4), .LVL_MAX(16)) dut (
        .vga_clk(vga_clk), .reset(reset), .frame_start(frame_start),
        .start_key(start_key), .game_over(game_over), .blank(blank),
        .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
        .scene(scene), .fade_busy(fade_busy),
        .red(red), .green(green), .blue(blue)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] scale(input logic [3:0] c, input int lvl);
        return 4'((int'(c) * lvl) / 16);
    endfunction

    // Advance one clock; the registered RGB for the previous inputs is compared here.
    task automatic tick();
        exp_t e;
        @(posedge vga_clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(e.tag, {red, green, blue}, e.rgb);
        end
    endtask

    task automatic pix(input string tag, input logic [3:0] r, input logic [3:0] g,
                       input logic [3:0] b, input logic bl, input int lvl);
        exp_t e;
        red_in = r; green_in = g; blue_in = b; blank = bl;
        e.tag = tag;
        e.rgb = bl ? {scale(r, lvl), scale(g, lvl), scale(b, lvl)} : 12'h000;
        exp_q.push_back(e);
        tick();
        blank = 1'b1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            tick();
        end
    endtask

    task automatic key_press();
        start_key = 1'b0;
        tick();
        start_key = 1'b1;
        tick();
    endtask

    initial begin
        // 1. reset state and unscaled pass-through
        #1;
        chk("rst_rgb", {red, green, blue}, 12'h000);
        chk("rst_scene", 12'(scene), 12'd0);
        chk("rst_busy", 12'(fade_busy), 12'd0);
        @(posedge vga_clk); @(posedge vga_clk); #1;
        reset = 1'b0;
        pix("t1_rgb", 4'hF, 4'h8, 4'h1, 1'b1, 16);
        chk("t1_scene", 12'(scene), 12'd0);
        chk("t1_busy", 12'(fade_busy), 12'd0);

        // 2/3. INTRO -> PLAY with held key, mid-fade scaling and blanking
        key_press();
        chk("t2_busy_out", 12'(fade_busy), 12'd1);
        frames(3);
        pix("t2_lvl16", 4'hF, 4'hF, 4'hF, 1'b1, 16);
        frames(1);
        pix("t2_lvl15", 4'hF, 4'hF, 4'hF, 1'b1, 15);
        frames(28);
        pix("t3_lvl8", 4'hF, 4'hF, 4'hF, 1'b1, 8);
        pix("t3_blank", 4'hF, 4'hF, 4'hF, 1'b0, 8);
        chk("t2_scene_hold", 12'(scene), 12'd0);
        frames(32);
        chk("t2_scene_black", 12'(scene), 12'd1);
        chk("t2_busy_in", 12'(fade_busy), 12'd1);
        pix("t2_lvl0", 4'hF, 4'h8, 4'h1, 1'b1, 0);
        frames(63);
        chk("t2_busy_63", 12'(fade_busy), 12'd1);
        pix("t2_in_lvl15", 4'hF, 4'hF, 4'hF, 1'b1, 15);
        frames(1);
        chk("t2_busy_done", 12'(fade_busy), 12'd0);
        chk("t2_scene_play", 12'(scene), 12'd1);
        pix("t2_full", 4'hF, 4'h8, 4'h1, 1'b1, 16);

        // 4. game_over beats a simultaneous key rise; repeat game_over mid-fade dropped
        start_key = 1'b0;
        tick();
        start_key = 1'b1;
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        chk("t4_busy", 12'(fade_busy), 12'd1);
        frames(10);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        frames(22);
        pix("t4_lvl8", 4'hF, 4'hF, 4'hF, 1'b1, 8);
        frames(32);
        chk("t4_scene_black", 12'(scene), 12'd2);
        frames(64);
        chk("t4_busy_done", 12'(fade_busy), 12'd0);
        chk("t4_scene_over", 12'(scene), 12'd2);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        tick();
        chk("t4_go_ignored", 12'(fade_busy), 12'd0);

        // 5. OVER -> INTRO
        key_press();
        chk("t5_busy", 12'(fade_busy), 12'd1);
        frames(64);
        chk("t5_scene_black", 12'(scene), 12'd0);
        frames(64);
        chk("t5_busy_done", 12'(fade_busy), 12'd0);
        repeat (3) tick();
        chk("t5_held_key", 12'(fade_busy), 12'd0);

        // 6. reset in the middle of a fade-in
        key_press();
        frames(64);
        chk("t6_scene_play", 12'(scene), 12'd1);
        frames(20);
        pix("t6_lvl5", 4'hF, 4'hF, 4'hF, 1'b1, 5);
        reset = 1'b1;
        #1;
        chk("t6_rst_scene", 12'(scene), 12'd0);
        chk("t6_rst_busy", 12'(fade_busy), 12'd0);
        chk("t6_rst_rgb", {red, green, blue}, 12'h000);
        start_key = 1'b0;
        tick();
        reset = 1'b0;
        pix("t6_after", 4'hF, 4'h8, 4'h1, 1'b1, 16);
        chk("t6_after_busy", 12'(fade_busy), 12'd0);

        if (exp_q.size() != 0) chk("sb_drain", 12'(exp_q.size()), 12'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
